// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;

  // Requester indices into the grant vector
  localparam int REQ_WB   = 0;
  localparam int REQ_HOST = 1;
  localparam int NUM_REQ  = 2;

endpackage : regfile_pkg

// File: rtl/host_starve_timer.sv
// Tracks how long the host has been kept waiting, decides when it must be forced
// through, and keeps a saturating count of those forced grants.
module host_starve_timer #(
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_host_valid,
  input  logic        i_host_grant,
  output logic        o_force,
  output logic [15:0] o_force_cnt
);

  localparam int WAIT_W = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(HOST_MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [15:0]       r_force_cnt;
  logic              w_at_max;

  // The counter saturates at MAX_WAIT, so equality is the same test as >=
  assign w_at_max    = (r_wait_cnt == MAX_WAIT);
  assign o_force     = i_host_valid && w_at_max;
  assign o_force_cnt = r_force_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_host_valid || i_host_grant) begin
      r_wait_cnt <= '0;
    end else if (!w_at_max) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_force_cnt <= '0;
    end else if (o_force && (r_force_cnt != 16'hFFFF)) begin
      r_force_cnt <= r_force_cnt + 16'd1;
    end
  end

endmodule : host_starve_timer

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback (priority) and the host path,
// with a registered write strobe/address/data stage feeding the register file.
module regfile_wr_arbiter #(
  parameter int DATA_W        = regfile_pkg::DATA_W,
  parameter int ADDR_W        = regfile_pkg::ADDR_W,
  parameter int HOST_MAX_WAIT = 4,
  parameter int ZERO_REG_RO   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [15:0]       force_cnt
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_force;
  logic               w_any_grant;
  logic               w_discard;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_data;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  host_starve_timer #(
    .HOST_MAX_WAIT (HOST_MAX_WAIT)
  ) u_host_starve_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_host_valid (host_valid),
    .i_host_grant (w_grant[REQ_HOST]),
    .o_force      (w_force),
    .o_force_cnt  (force_cnt)
  );

  // A forced host grant pre-empts writeback; otherwise writeback wins any tie
  always_comb begin
    w_grant           = '0;
    w_grant[REQ_HOST] = w_force || (host_valid && !wb_valid);
    w_grant[REQ_WB]   = wb_valid && !w_force;
  end

  assign wb_ready    = w_grant[REQ_WB];
  assign host_ready  = w_grant[REQ_HOST];
  assign w_any_grant = |w_grant;

  assign w_win_addr = w_grant[REQ_HOST] ? host_addr : wb_addr;
  assign w_win_data = w_grant[REQ_HOST] ? host_data : wb_data;

  // Index 0 writes still handshake but never reach the register file
  assign w_discard = (ZERO_REG_RO != 0) && (w_win_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_any_grant && !w_discard) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_win_addr;
      r_wr_data <= w_win_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table plus hand sequences for
// starvation, async reset and the HOST_MAX_WAIT=0 saturation case.
module tb_regfile_wr_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  // DUT A: HOST_MAX_WAIT = 4
  logic          a_wb_valid = 0, a_host_valid = 0;
  logic [AW-1:0] a_wb_addr = 0, a_host_addr = 0;
  logic [DW-1:0] a_wb_data = 0, a_host_data = 0;
  logic          a_wb_ready, a_host_ready, a_en;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [15:0]   a_fcnt;

  // DUT B: HOST_MAX_WAIT = 0
  logic          b_wb_valid = 0, b_host_valid = 0;
  logic [AW-1:0] b_wb_addr = 0, b_host_addr = 0;
  logic [DW-1:0] b_wb_data = 0, b_host_data = 0;
  logic          b_wb_ready, b_host_ready, b_en;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [15:0]   b_fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HOST_MAX_WAIT(4), .ZERO_REG_RO(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(a_wb_valid), .wb_ready(a_wb_ready), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
    .host_valid(a_host_valid), .host_ready(a_host_ready), .host_addr(a_host_addr), .host_data(a_host_data),
    .rf_wr_en(a_en), .rf_wr_addr(a_addr), .rf_wr_data(a_data), .force_cnt(a_fcnt)
  );

  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HOST_MAX_WAIT(0), .ZERO_REG_RO(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(b_wb_valid), .wb_ready(b_wb_ready), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .host_valid(b_host_valid), .host_ready(b_host_ready), .host_addr(b_host_addr), .host_data(b_host_data),
    .rf_wr_en(b_en), .rf_wr_addr(b_addr), .rf_wr_data(b_data), .force_cnt(b_fcnt)
  );

  typedef struct {
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          host_valid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          exp_wb_ready;
    logic          exp_host_ready;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    a_wb_valid = wv; a_wb_addr = wa; a_wb_data = wd;
    a_host_valid = hv; a_host_addr = ha; a_host_data = hd;
  endtask

  initial begin
    // idle, wb only, host only, same-address collision (wb then host), zero-reg wb/host, idle
    vecs[0] = '{0, 0, 0,                     0, 0, 0,     0, 0, 0, 0, 0};
    vecs[1] = '{1, 3, 64'hDEAD_BEEF_0123_4567, 0, 0, 0,   1, 0, 1, 3, 64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{0, 0, 0,                     1, 9, 64'h55, 0, 1, 1, 9, 64'h55};
    vecs[3] = '{1, 7, 64'h1,                 1, 7, 64'h2, 1, 0, 1, 7, 64'h1};
    vecs[4] = '{0, 0, 0,                     1, 7, 64'h2, 0, 1, 1, 7, 64'h2};
    vecs[5] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,   1, 0, 0, 7, 64'h2};
    vecs[6] = '{0, 0, 0,                     1, 0, 64'h77, 0, 1, 0, 7, 64'h2};
    vecs[7] = '{0, 0, 0,                     0, 0, 0,     0, 0, 0, 7, 64'h2};

    repeat (2) @(negedge clk);
    chk("reset_en", a_en, 0);
    chk("reset_addr", a_addr, 0);
    chk("reset_data", a_data, 0);
    chk("reset_fcnt", a_fcnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a(vecs[i].wb_valid, vecs[i].wb_addr, vecs[i].wb_data,
              vecs[i].host_valid, vecs[i].host_addr, vecs[i].host_data);
      #1;
      chk($sformatf("v%0d_wb_ready", i), a_wb_ready, vecs[i].exp_wb_ready);
      chk($sformatf("v%0d_host_ready", i), a_host_ready, vecs[i].exp_host_ready);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), a_en, vecs[i].exp_en);
      chk($sformatf("v%0d_addr", i), a_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_data", i), a_data, vecs[i].exp_data);
      chk($sformatf("v%0d_fcnt", i), a_fcnt, 0);
    end

    // Starvation: host forced through on the 5th cycle, wb stalled only then
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive_a(1, 4, 64'hAAAA, 1, 5, 64'hBBBB);
      #1;
      chk($sformatf("starve_c%0d_wb_ready", c), a_wb_ready, (c == 5) ? 0 : 1);
      chk($sformatf("starve_c%0d_host_ready", c), a_host_ready, (c == 5) ? 1 : 0);
      @(posedge clk);
      #1;
      chk($sformatf("starve_c%0d_addr", c), a_addr, (c == 5) ? 5 : 4);
      chk($sformatf("starve_c%0d_fcnt", c), a_fcnt, (c == 5) ? 1 : 0);
    end
    @(negedge clk);
    drive_a(1, 4, 64'hAAAA, 0, 0, 0);
    #1;
    chk("starve_after_wb_ready", a_wb_ready, 1);
    @(posedge clk);
    #1;
    chk("starve_after_data", a_data, 64'hAAAA);
    chk("starve_after_fcnt", a_fcnt, 1);

    // Async reset mid-write: outputs clear without any clock edge
    @(negedge clk);
    drive_a(1, 3, 64'h1234, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("prerst_en", a_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", a_en, 0);
    chk("async_rst_addr", a_addr, 0);
    chk("async_rst_data", a_data, 0);
    chk("async_rst_fcnt", a_fcnt, 0);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // HOST_MAX_WAIT=0: host wins every cycle, force count saturates
    @(negedge clk);
    b_wb_valid = 1; b_wb_addr = 6; b_wb_data = 64'h66;
    b_host_valid = 1; b_host_addr = 8; b_host_data = 64'h88;
    #1;
    chk("mw0_host_ready", b_host_ready, 1);
    chk("mw0_wb_ready", b_wb_ready, 0);
    @(posedge clk);
    #1;
    chk("mw0_en", b_en, 1);
    chk("mw0_addr", b_addr, 8);
    chk("mw0_fcnt1", b_fcnt, 1);
    repeat (65533) @(posedge clk);
    #1;
    chk("mw0_fcnt_fffe", b_fcnt, 16'hFFFE);
    chk("mw0_host_ready_late", b_host_ready, 1);
    @(posedge clk);
    #1;
    chk("mw0_fcnt_ffff", b_fcnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("mw0_fcnt_sat", b_fcnt, 16'hFFFF);
    chk("mw0_data", b_data, 64'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
